buffer_reader: RTL and testbench

- Consumer-side reader for the 8-deep 16-bit clock-crossing buffer; sits in the clk_2 (slow) domain.
- Issues one pop request per word while the buffer is non-empty, then captures the returned word.
- Presents each word to the display path for a fixed dwell time.
- Counts consumed words; flags non-monotonic sequences (Fibonacci/Timer outputs must never decrease) and missing-data timeouts.

---
 rtl/reader_pkg.sv | 11 +
 rtl/reader_dwell_counter.sv | 34 +++
 rtl/buffer_reader.sv | 151 +++++++++++++++
 tb/tb_buffer_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reader_pkg.sv
// Shared types and widths for the slow-domain buffer reader.
package reader_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/reader_dwell_counter.sv
// Loadable down-counter with zero flag; used for both dwell and response-wait timing.
module reader_dwell_counter
  import reader_pkg::*;
(
  input  logic             clk_2,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_2) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/buffer_reader.sv
// Pops words from the clock-crossing buffer, presents each for a fixed dwell,
// and tracks word count, sequence ordering and missing-response errors.
//
//   state | meaning
//   IDLE  | waiting for a non-empty buffer; rd_en fires on leaving
//   WAIT  | pop issued, waiting for data_2_valid or the timeout
//   HOLD  | captured word presented with data_out_valid high
module buffer_reader
  import reader_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 8,
  parameter bit CHECK_MONO     = 1'b1
) (
  input  logic              clk_2,
  input  logic              rst,
  input  logic              buffer_empty,
  input  logic              data_2_valid,
  input  logic [DATA_W-1:0] data_2,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [CNT_W-1:0]  word_count,
  output logic              seq_error,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              seq_err_q, seq_err_d;
  logic              tmo_err_q, tmo_err_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;

  logic hold_load, hold_dec, hold_zero;
  logic wait_load, wait_dec, wait_zero;

  reader_dwell_counter u_hold_cnt (
    .clk_2    (clk_2),
    .rst      (rst),
    .load     (hold_load),
    .dec      (hold_dec),
    .load_val (HOLD_LOAD),
    .zero     (hold_zero)
  );

  reader_dwell_counter u_wait_cnt (
    .clk_2    (clk_2),
    .rst      (rst),
    .load     (wait_load),
    .dec      (wait_dec),
    .load_val (WAIT_LOAD),
    .zero     (wait_zero)
  );

  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    count_d     = count_q;
    seq_err_d   = seq_err_q;
    tmo_err_d   = tmo_err_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    hold_load   = 1'b0;
    hold_dec    = 1'b0;
    wait_load   = 1'b0;
    wait_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!buffer_empty) begin
          rd_en_d   = 1'b1;
          wait_load = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (data_2_valid) begin
          data_out_d  = data_2;
          valid_d     = 1'b1;
          count_d     = count_q + CNT_W'(1);
          // Equal words are legal; only a strict decrease is an error.
          if (CHECK_MONO && have_prev_q && (data_2 < prev_q)) begin
            seq_err_d = 1'b1;
          end
          prev_d      = data_2;
          have_prev_d = 1'b1;
          hold_load   = 1'b1;
          state_d     = HOLD;
        end else if (wait_zero) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_dec = 1'b1;
        end
      end
      HOLD: begin
        if (hold_zero) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          hold_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
      seq_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      seq_err_q   <= seq_err_d;
      tmo_err_q   <= tmo_err_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign rd_en          = rd_en_q;
  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign word_count     = count_q;
  assign seq_error      = seq_err_q;
  assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: buffer model, timestamp-based reference model,
// directed sequences, a vector table and a randomized soak.
module tb_buffer_reader;
  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic        clk_2 = 1'b0;
  logic        rst = 1'b1;
  logic        buffer_empty = 1'b1;
  logic        data_2_valid = 1'b0;
  logic [15:0] data_2 = '0;

  logic        rd_en, dv, seq, to;
  logic [15:0] dout;
  logic [7:0]  wc;
  logic        rd_en_n, dv_n, seq_n, to_n;
  logic [15:0] dout_n;
  logic [7:0]  wc_n;

  buffer_reader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .CHECK_MONO(1'b1)) dut (
    .clk_2(clk_2), .rst(rst), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .data_2(data_2), .rd_en(rd_en), .data_out(dout), .data_out_valid(dv),
    .word_count(wc), .seq_error(seq), .timeout_err(to));

  buffer_reader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .CHECK_MONO(1'b0)) dut_nm (
    .clk_2(clk_2), .rst(rst), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
    .data_2(data_2), .rd_en(rd_en_n), .data_out(dout_n), .data_out_valid(dv_n),
    .word_count(wc_n), .seq_error(seq_n), .timeout_err(to_n));

  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-edge timestamps of the last pop request and capture.
  int          k = 0;
  int          next_free = 0;
  int          t_req = -100;
  int          t_cap = -100;
  bit          waiting = 0;
  logic [15:0] m_dout = '0, m_prev = '0;
  bit          m_have = 0, m_seq = 0, m_to = 0, m_rd = 0, m_val = 0;
  logic [7:0]  m_cnt = '0;

  task automatic model_step(input logic r, input logic empty, input logic v, input logic [15:0] d);
    k++;
    if (r) begin
      next_free = k + 1; t_req = -100; t_cap = -100; waiting = 0;
      m_dout = '0; m_prev = '0; m_have = 0; m_seq = 0; m_to = 0; m_cnt = '0;
    end else if (waiting) begin
      if (v) begin
        m_dout = d;
        m_cnt  = m_cnt + 8'd1;
        if (m_have && (d < m_prev)) m_seq = 1;
        m_prev = d; m_have = 1;
        t_cap = k; next_free = k + HOLD + 1; waiting = 0;
      end else if (k == t_req + TMO) begin
        m_to = 1; waiting = 0; next_free = k + 1;
      end
    end else if ((k >= next_free) && !empty) begin
      t_req = k; waiting = 1;
    end
    m_rd  = (k == t_req);
    m_val = (k >= t_cap) && (k < t_cap + HOLD);
  endtask

  initial forever begin
    @(posedge clk_2);
    model_step(rst, buffer_empty, data_2_valid, data_2);
    #1;
    chk("rd_en", 32'(rd_en), 32'(m_rd));
    chk("data_out", 32'(dout), 32'(m_dout));
    chk("valid", 32'(dv), 32'(m_val));
    chk("word_count", 32'(wc), 32'(m_cnt));
    chk("seq_error", 32'(seq), 32'(m_seq));
    chk("timeout_err", 32'(to), 32'(m_to));
    chk("nm_rd_en", 32'(rd_en_n), 32'(m_rd));
    chk("nm_data_out", 32'(dout_n), 32'(m_dout));
    chk("nm_valid", 32'(dv_n), 32'(m_val));
    chk("nm_word_count", 32'(wc_n), 32'(m_cnt));
    chk("nm_seq_error", 32'(seq_n), 32'd0);
    chk("nm_timeout_err", 32'(to_n), 32'(m_to));
  end

  // Buffer model: answers a pop after 'lat' cycles unless muted.
  logic [15:0] bufq[$];
  int lat = 1;
  bit mute = 0;
  bit spur_en = 0;
  int cd = 0;

  initial forever begin
    @(negedge clk_2);
    #1;
    data_2_valid = 1'b0;
    if (rst) begin
      cd = 0;
    end else begin
      if (rd_en && !mute) cd = lat;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          data_2_valid = 1'b1;
          data_2 = (bufq.size() > 0) ? bufq.pop_front() : 16'($urandom);
        end
      end else if (spur_en && !rd_en && ($urandom_range(0, 2) == 0)) begin
        data_2_valid = 1'b1;
        data_2 = 16'($urandom);
      end
    end
    buffer_empty = (bufq.size() == 0);
  end

  int obs_pulses, obs_maxrun, obs_valid;
  int rd_times[$];
  logic [15:0] caps[$];

  task automatic observe(input int n);
    int run;
    logic pv;
    run = 0; pv = 1'b0;
    obs_pulses = 0; obs_maxrun = 0; obs_valid = 0;
    rd_times.delete(); caps.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_2);
      if (rd_en) begin
        run++;
        if (run == 1) begin obs_pulses++; rd_times.push_back(i); end
        if (run > obs_maxrun) obs_maxrun = run;
      end else begin
        run = 0;
      end
      if (dv) obs_valid++;
      if (dv && !pv) caps.push_back(dout);
      pv = dv;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_2);
    rst = 1'b1; bufq.delete(); mute = 0; spur_en = 0; lat = 1;
    @(negedge clk_2);
    @(negedge clk_2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          exp_seq;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int fib[5];
    int i_rd, i_to;
    bit found;
    logic [15:0] w;

    vecs[0] = '{16'h0010, 16'h000F, 1'b1};
    vecs[1] = '{16'h000F, 16'h0010, 1'b0};
    vecs[2] = '{16'h0007, 16'h0007, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b0};
    fib = '{1, 1, 2, 3, 5};

    // Single word, answer during the rd_en cycle
    do_reset();
    bufq.push_back(16'h0005);
    observe(20);
    chk("t1_pulses", obs_pulses, 1);
    chk("t1_pulse_len", obs_maxrun, 1);
    chk("t1_valid_cycles", obs_valid, HOLD);
    chk("t1_data_out", 32'(dout), 32'h5);
    chk("t1_word_count", 32'(wc), 1);
    chk("t1_seq", 32'(seq), 0);
    chk("t1_to", 32'(to), 0);

    // Fibonacci run with a one-cycle registered buffer response
    do_reset();
    lat = 2;
    foreach (fib[i]) bufq.push_back(16'(fib[i]));
    observe(50);
    chk("t2_pulses", obs_pulses, 5);
    for (int i = 1; i < rd_times.size(); i++) chk("t2_spacing", rd_times[i] - rd_times[i-1], 7);
    chk("t2_caps", caps.size(), 5);
    for (int i = 0; i < caps.size() && i < 5; i++) chk("t2_word", 32'(caps[i]), fib[i]);
    chk("t2_word_count", 32'(wc), 5);
    chk("t2_seq", 32'(seq), 0);

    // Ordering table, with and without the monotonic check
    foreach (vecs[v]) begin
      do_reset();
      bufq.push_back(vecs[v].a);
      bufq.push_back(vecs[v].b);
      observe(25);
      chk("t3_data_out", 32'(dout), 32'(vecs[v].b));
      chk("t3_word_count", 32'(wc), 2);
      chk("t3_seq", 32'(seq), 32'(vecs[v].exp_seq));
      chk("t3_seq_nomono", 32'(seq_n), 0);
    end

    // Unanswered pop, then a normal pop
    do_reset();
    mute = 1;
    bufq.push_back(16'h0042);
    i_rd = -1; i_to = -1;
    for (int i = 0; i < 40 && i_to < 0; i++) begin
      @(negedge clk_2);
      if (rd_en && i_rd < 0) i_rd = i;
      if (to) i_to = i;
    end
    mute = 0;
    chk("t4_timeout_delay", i_to - i_rd, TMO);
    chk("t4_word_count", 32'(wc), 0);
    chk("t4_valid", 32'(dv), 0);
    observe(15);
    chk("t4_repop_pulses", obs_pulses, 1);
    chk("t4_repop_word", 32'(dout), 32'h42);
    chk("t4_word_count2", 32'(wc), 1);
    chk("t4_to_sticky", 32'(to), 1);

    // Reset in the middle of a dwell
    do_reset();
    bufq.push_back(16'h0009);
    bufq.push_back(16'h0003);
    bufq.push_back(16'h1234);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_2);
      if (dv && wc == 8'd3) found = 1;
    end
    chk("t5_reached_hold", 32'(found), 1);
    chk("t5_seq_pre", 32'(seq), 1);
    rst = 1'b1;
    @(posedge clk_2);
    #1;
    chk("t5_rd_en", 32'(rd_en), 0);
    chk("t5_data_out", 32'(dout), 0);
    chk("t5_valid", 32'(dv), 0);
    chk("t5_word_count", 32'(wc), 0);
    chk("t5_seq", 32'(seq), 0);
    chk("t5_to", 32'(to), 0);
    @(negedge clk_2);
    rst = 1'b0;
    observe(6);
    chk("t5_no_pop_empty", obs_pulses, 0);
    bufq.push_back(16'h0077);
    observe(12);
    chk("t5_pop_after", obs_pulses, 1);
    chk("t5_word", 32'(dout), 32'h77);
    chk("t5_word_count2", 32'(wc), 1);

    // 257 words with spurious valid pulses outside WAIT
    do_reset();
    spur_en = 1;
    for (int i = 0; i < 257; i++) bufq.push_back(16'(i * 3));
    observe(257 * (HOLD + 2) + 20);
    spur_en = 0;
    chk("t6_pulses", obs_pulses, 257);
    chk("t6_word_count", 32'(wc), 1);
    chk("t6_data_out", 32'(dout), 32'(256 * 3));
    chk("t6_seq", 32'(seq), 0);
    chk("t6_to", 32'(to), 0);

    // Randomized soak against the reference model
    do_reset();
    w = 16'h0100;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_2);
      rst = ($urandom_range(0, 199) == 0);
      lat = $urandom_range(1, 10);
      mute = ($urandom_range(0, 9) == 0);
      spur_en = ($urandom_range(0, 3) == 0);
      if (bufq.size() < 3 && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 7) == 0) w = 16'($urandom);
        else w = w + 16'($urandom_range(0, 2));
        bufq.push_back(w);
      end
    end
    rst = 1'b0; mute = 0; spur_en = 0;
    repeat (3) @(negedge clk_2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
